m_imem_loader: RTL

- Serial program loader: the writer side of the instruction-memory port that the processor fetch stage reads.
- Receives an 8N1 UART byte stream from the host PC and assembles 32-bit instruction words.
- Writes the words sequentially into instruction memory through a one-cycle write strobe.
- Holds the processor in reset (w_busy) until the load completes, so programs can be replaced without re-synthesising the memory init file.

---
 rtl/m_imem_loader_pkg.sv | 23 ++
 rtl/m_imem_loader_uart_rx.sv | 96 +++++++++
 rtl/m_imem_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/m_imem_loader_pkg.sv
// rtl/m_imem_loader_pkg.sv - shared state encodings and frame constants for the instruction-memory loader.
package m_imem_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_WORD   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/m_imem_loader_uart_rx.sv
// rtl/m_imem_loader_uart_rx.sv - 8N1 UART byte receiver with input synchroniser and mid-bit sampling.
module m_uart_rx
  import m_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rxd,
  output logic       w_start,
  output logic       w_byte_valid,
  output logic [7:0] w_byte,
  output logic       w_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t       r_state;
  rx_state_t       w_next;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_tick;
  logic            w_half;

  assign w_tick = (r_cnt == FULL);
  assign w_half = (r_cnt == HALF);
  assign w_byte = r_shift;

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      RX_IDLE:  if (r_prev && !r_sync2) w_next = RX_START;
      // A line that is high again at mid start bit was only a glitch.
      RX_START: if (w_half) begin
        if (r_sync2) begin
          w_next = RX_IDLE;
        end else begin
          w_next  = RX_DATA;
          w_start = 1'b1;
        end
      end
      RX_DATA:  if (w_tick && r_bit == 3'd7) w_next = RX_STOP;
      RX_STOP:  if (w_tick) begin
        w_next       = RX_IDLE;
        w_byte_valid = r_sync2;
        w_frame_err  = !r_sync2;
      end
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync1 <= w_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_state == RX_IDLE || (r_state == RX_START && w_half) || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == RX_START) begin
        r_bit <= '0;
      end
      if (r_state == RX_DATA && w_tick) begin
        r_shift <= {r_sync2, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_imem_loader.sv
// rtl/m_imem_loader.sv - UART program loader: frames header and words, writes them to instruction memory.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 11,
  parameter int MAX_WORDS    = 2048
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [31:0]       w_wdata,
  output logic              w_busy,
  output logic              w_done,
  output logic              w_err
);

  localparam logic [15:0] MAX_N     = 16'(MAX_WORDS);
  localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic              w_start;
  logic              w_byte_valid;
  logic [7:0]        w_byte;
  logic              w_frame_err;
  logic [7:0]        r_n_hi;
  logic [15:0]       r_n;
  logic [15:0]       w_n_full;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_bidx;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;
  logic              w_last;

  m_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_rxd       (w_rxd),
    .w_start     (w_start),
    .w_byte_valid(w_byte_valid),
    .w_byte      (w_byte),
    .w_frame_err (w_frame_err)
  );

  assign w_n_full = {r_n_hi, w_byte};
  assign w_last   = ((16'(r_idx) + 16'd1) == r_n);
  assign w_we     = (r_state == S_WRITE);
  assign w_busy   = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) ||
                    (r_state == S_WORD)   || (r_state == S_WRITE);
  assign w_addr   = r_idx;
  assign w_wdata  = r_wdata;
  assign w_done   = r_done;
  assign w_err    = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_HDR_HI;
      S_HDR_HI: begin
        if (w_frame_err)       w_next = S_ERR;
        else if (w_byte_valid) w_next = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (w_frame_err) begin
          w_next = S_ERR;
        end else if (w_byte_valid) begin
          if (w_n_full == 16'd0)      w_next = S_DONE;
          else if (w_n_full > MAX_N)  w_next = S_ERR;
          else                        w_next = S_WORD;
        end
      end
      S_WORD: begin
        if (w_frame_err)                              w_next = S_ERR;
        else if (w_byte_valid && r_bidx == LAST_BYTE) w_next = S_WRITE;
      end
      S_WRITE:  w_next = w_last ? S_DONE : S_WORD;
      // A start bit landing in the single DONE/ERR cycle still begins a frame.
      S_DONE, S_ERR: w_next = w_start ? S_HDR_HI : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_n_hi  <= '0;
      r_n     <= '0;
      r_idx   <= '0;
      r_bidx  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_HDR_HI && w_byte_valid) begin
        r_n_hi <= w_byte;
      end
      if (r_state == S_HDR_LO && w_byte_valid) begin
        r_n    <= w_n_full;
        r_idx  <= '0;
        r_bidx <= '0;
      end
      if (r_state == S_WORD && w_byte_valid) begin
        r_wdata <= {r_wdata[23:0], w_byte};
        r_bidx  <= r_bidx + 1'b1;
      end
      // Holding the index on the last word keeps w_addr within 0..N-1.
      if (r_state == S_WRITE && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_next == S_HDR_HI && r_state != S_HDR_HI) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_next == S_DONE) r_done <= 1'b1;
      if (w_next == S_ERR)  r_err  <= 1'b1;
    end
  end

endmodule
